// File: rtl/bcd_input_conditioner.sv
// Conditions a raw push-button and raw switches into clean enter/mode/load inputs for a BCD counter.
// Latency: enter pulses DEBOUNCE_CYCLES+3 edges after the button is first sampled high; mode follows in 3 edges.
// No backpressure: the pulse is a one-cycle strobe. Macro BCD_RANGE_CHECK_EN rejects non-BCD loads.
module bcd_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enter_btn,
  input  logic       mode_sw,
  input  logic [3:0] load_sw,
  output logic       enter,
  output logic       mode,
  output logic [3:0] load,
  output logic       load_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    HELD,
    WAIT_RELEASE
  } state_t;

  // Synchronizer stages, bit order {enter_btn, mode_sw, load_sw[3:0]}
  logic [5:0] sync1, sync2;
  logic       btn_s;
  logic       mode_s;
  logic [3:0] load_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             enter_q, enter_nxt;
  logic             mode_q;
  logic [3:0]       load_q, load_nxt;
  logic             accept;

  assign btn_s  = sync2[5];
  assign mode_s = sync2[4];
  assign load_s = sync2[3:0];

  // Two-flop synchronizer on every raw asynchronous input
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {enter_btn, mode_sw, load_sw};
      sync2 <= sync1;
    end
  end

  // Mode is a plain extra register stage, independent of the button FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mode_q <= 1'b0;
    else       mode_q <= mode_s;
  end

  // The press is accepted on the last debounce cycle while still held high
  assign accept = (state == WAIT_PRESS) && btn_s && (cnt == CNT_LAST);

  // Next state, debounce counter, pulse request and load capture
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enter_nxt = 1'b0;
    load_nxt  = load_q;
    case (state)
      IDLE: begin
        // Load follows the switches only while no press is in progress
        load_nxt = load_s;
        if (btn_s) begin
          state_nxt = WAIT_PRESS;
          cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
`ifdef BCD_RANGE_CHECK_EN
          enter_nxt = (load_q <= 4'd9);
`else
          enter_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = WAIT_RELEASE;
          cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      enter_q <= 1'b0;
      load_q  <= 4'b0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      enter_q <= enter_nxt;
      load_q  <= load_nxt;
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  logic load_err_q;

  // Error flag reflects the verdict of the most recent accepted press
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       load_err_q <= 1'b0;
    else if (accept) load_err_q <= (load_q > 4'd9);
  end

  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  assign enter = enter_q;
  assign mode  = mode_q;
  assign load  = load_q;

endmodule

// File: doc/bcd_input_conditioner.md
BCD_INPUT_CONDITIONER -- requirements
Module: bcd_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized samples needed to accept a button level change (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port enter_btn  input  1  raw, asynchronous, bouncing push-button; high = pressed.
REQ-005 SHALL have port mode_sw  input  1  raw, asynchronous slide switch.
REQ-006 SHALL have port load_sw  input  4  raw, asynchronous BCD digit switches.
REQ-007 SHALL have port enter  output  1  one-cycle registered pulse per accepted press; feeds the counter's enter input.
REQ-008 SHALL have port mode  output  1  synchronized mode level; feeds the counter's mode input.
REQ-009 SHALL have port load  output  4  captured digit; feeds the counter's load input.
REQ-010 SHALL have port load_err  output  1  registered flag: last press was rejected as a non-BCD digit.

Function
REQ-011 SHALL pass enter_btn, mode_sw and load_sw[3:0] each through a 2-flop synchronizer before any other use.
REQ-012 SHALL implement button FSM states IDLE, WAIT_PRESS, HELD, WAIT_RELEASE with a debounce counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-013 IDLE: synced button 1 -> WAIT_PRESS, counter cleared; otherwise stay.
REQ-014 WAIT_PRESS: synced button 0 -> IDLE (bounce rejected); else counter increments; counter reaching DEBOUNCE_CYCLES-1 with button 1 -> HELD.
REQ-015 The WAIT_PRESS->HELD transition SHALL register enter=1 for exactly one cycle; latency DEBOUNCE_CYCLES+3 rising edges from the first edge sampling enter_btn high.
REQ-016 HELD: synced button 0 -> WAIT_RELEASE, counter cleared; no further pulse however long the button is held.
REQ-017 WAIT_RELEASE: synced button 1 -> HELD; else counter increments; counter reaching DEBOUNCE_CYCLES-1 with button 0 -> IDLE.
REQ-018 load SHALL track the synced load_sw every cycle only in IDLE, and SHALL hold its value in all other states, so load is stable for at least DEBOUNCE_CYCLES cycles before and during the enter pulse.
REQ-019 mode SHALL be the synced mode_sw registered once more (3-edge latency), independent of the FSM.
REQ-020 A press SHALL emit at most one enter pulse; a reset during any state SHALL abort it with no pulse.

Reset
REQ-021 rstn low SHALL immediately force state IDLE, counter 0, all synchronizer flops 0, enter=0, mode=0, load=4'b0000, load_err=0.
REQ-022 After rstn deasserts, a button already held high SHALL be treated as a new press and debounced normally.

Configuration
REQ-023 Macro BCD_RANGE_CHECK_EN defined: at the WAIT_PRESS->HELD transition, held load >9 SHALL suppress the enter pulse and set load_err=1; load <=9 SHALL pulse and clear load_err.
REQ-024 BCD_RANGE_CHECK_EN undefined: every accepted press SHALL pulse regardless of value, and load_err SHALL be tied to 0.

Verification
REQ-025 Clean press (DEBOUNCE_CYCLES=4): enter_btn 0->1 held for 20 cycles -> one enter pulse exactly 7 edges later, then no pulse until release.
REQ-026 Bounce: enter_btn pulses high 2 cycles, low 1, repeated 5 times, then stays high -> no pulse during bounce, exactly one pulse 7 edges after the final rise.
REQ-027 Load capture: load_sw=4'b0101, press, change load_sw to 4'b0011 during HELD -> load=0101 during the pulse; load=0011 three edges after return to IDLE.
REQ-028 Range check (macro defined): load_sw=4'b1100 then press -> no pulse, load_err=1; then load_sw=4'b0111 and press -> pulse, load_err=0. Macro undefined: both presses pulse, load_err stays 0.
REQ-029 Reset mid-press: rstn low for 1 cycle while in WAIT_PRESS -> all outputs 0 asynchronously, no pulse; button still high after reset -> pulse 7 edges after rstn rises.
REQ-030 Mode: mode_sw toggles 0->1 -> mode=1 after 3 edges, no enter pulse generated.
